// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_pkg
// Description : Default half-period counts for the LED blinker and the
//               counter-width helper shared by the divider instances.
// Revision    : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

    // Half-period counts for a 25 MHz oscillator
    localparam int c_DEFAULT_COUNT_10HZ = 1250000;
    localparam int c_DEFAULT_COUNT_5HZ  = 2500000;
    localparam int c_DEFAULT_COUNT_2HZ  = 6250000;
    localparam int c_DEFAULT_COUNT_1HZ  = 12500000;

    // Counter width able to hold 0..n-1; never narrower than one bit so that
    // n = 1 still yields a legal (constant-zero) counter.
    function automatic int f_cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : led_blink_pkg
`default_nettype wire

// File: rtl/led_blink_if.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_if
// Description : Bundle of the four LED pin levels. The blinker side drives
//               them (master), the board/observer side reads them (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface led_blink_if;

    logic [3:0] led;

    modport master (output led);
    modport slave  (input  led);

endinterface : led_blink_if
`default_nettype wire

// File: rtl/led_toggle_div.sv
`default_nettype none
// ============================================================================
// Module      : led_toggle_div
// Description : Terminal-count divider. Counts 0..g_COUNT-1 and inverts its
//               registered output on the terminal count, giving a 50 % duty
//               square wave of period 2*g_COUNT clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module led_toggle_div
    import led_blink_pkg::*;
#(
    parameter int g_COUNT = 1
) (
    input  wire logic i_Clk,
    input  wire logic i_Rst,
    output logic      o_Toggle
);

    localparam int                  c_CNT_W    = f_cnt_width(g_COUNT);
    localparam logic [c_CNT_W-1:0]  c_TERMINAL = c_CNT_W'(g_COUNT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    // A count below one has no meaningful half-period; refuse to elaborate.
    generate
        if (g_COUNT < 1) begin : g_bad_count
            $error("led_toggle_div: g_COUNT must be >= 1");
        end
    endgenerate

    // Initialisers make a power-up with reset tied low look like a fresh reset.
    logic [c_CNT_W-1:0] r_cnt = '0;
    logic               r_led = 1'b0;

    // Count to the terminal value, then wrap and flip the LED; reset beats the
    // terminal count so a coincident reset leaves the LED low.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (r_cnt == c_TERMINAL) begin
            r_cnt <= '0;
            r_led <= ~r_led;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign o_Toggle = r_led;

endmodule : led_toggle_div
`default_nettype wire

// File: rtl/led_blink.sv
`default_nettype none
// ============================================================================
// Module      : led_blink
// Description : Free-running four-LED blinker. Each LED is driven straight
//               from the flop of its own divider; the dividers share only the
//               clock and the common reset.
// Revision    : 1.0 - initial release
// ============================================================================
module led_blink
    import led_blink_pkg::*;
#(
    parameter int g_COUNT_10HZ = c_DEFAULT_COUNT_10HZ,
    parameter int g_COUNT_5HZ  = c_DEFAULT_COUNT_5HZ,
    parameter int g_COUNT_2HZ  = c_DEFAULT_COUNT_2HZ,
    parameter int g_COUNT_1HZ  = c_DEFAULT_COUNT_1HZ
) (
    input  wire logic i_Clk,
    input  wire logic i_Rst,
    output logic      o_LED_1,
    output logic      o_LED_2,
    output logic      o_LED_3,
    output logic      o_LED_4
);

    logic [3:0] w_led;

    led_toggle_div #(.g_COUNT(g_COUNT_10HZ)) u_div_10hz (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .o_Toggle (w_led[0])
    );

    led_toggle_div #(.g_COUNT(g_COUNT_5HZ)) u_div_5hz (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .o_Toggle (w_led[1])
    );

    led_toggle_div #(.g_COUNT(g_COUNT_2HZ)) u_div_2hz (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .o_Toggle (w_led[2])
    );

    led_toggle_div #(.g_COUNT(g_COUNT_1HZ)) u_div_1hz (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .o_Toggle (w_led[3])
    );

    assign o_LED_1 = w_led[0];
    assign o_LED_2 = w_led[1];
    assign o_LED_3 = w_led[2];
    assign o_LED_4 = w_led[3];

endmodule : led_blink
`default_nettype wire

// File: tb/tb_led_blink.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_led_blink
// Description : Scoreboard bench for led_blink. The stimulus process drives
//               reset and pushes the expected LED levels for every edge; a
//               monitor pops and compares on the falling edge, and also
//               measures every high/low interval against N.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink;

    localparam int c_N [4] = '{5, 10, 25, 50};

    typedef struct {
        bit         rst;
        int         edge_no;
        logic [3:0] exp_main;
        logic [3:0] exp_one;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0] w_main;
    logic [3:0] w_one;

    led_blink_if u_main_if ();
    led_blink_if u_one_if  ();

    assign u_main_if.led = w_main;
    assign u_one_if.led  = w_one;

    always #1 clk = ~clk;

    led_blink #(
        .g_COUNT_10HZ (5),
        .g_COUNT_5HZ  (10),
        .g_COUNT_2HZ  (25),
        .g_COUNT_1HZ  (50)
    ) u_dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .o_LED_1 (w_main[0]),
        .o_LED_2 (w_main[1]),
        .o_LED_3 (w_main[2]),
        .o_LED_4 (w_main[3])
    );

    led_blink #(
        .g_COUNT_10HZ (1),
        .g_COUNT_5HZ  (1),
        .g_COUNT_2HZ  (1),
        .g_COUNT_1HZ  (1)
    ) u_dut_one (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .o_LED_1 (w_one[0]),
        .o_LED_2 (w_one[1]),
        .o_LED_3 (w_one[2]),
        .o_LED_4 (w_one[3])
    );

    sb_t q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  k        = 0;   // edges since reset release (reference model state)
    int  edge_cnt = 0;

    // Reference model: after k edges out of reset, an LED with half-period N
    // has toggled floor(k/N) times, so its level is the parity of that.
    task automatic do_cycle(input bit rst_v);
        sb_t e;
        rst = rst_v;
        @(posedge clk);
        edge_cnt++;
        if (rst_v) k = 0;
        else       k++;
        e.rst     = rst_v;
        e.edge_no = edge_cnt;
        for (int i = 0; i < 4; i++) begin
            e.exp_main[i] = ((k / c_N[i]) % 2) == 1;
            e.exp_one[i]  = (k % 2) == 1;
        end
        q.push_back(e);
        #0.5;
    endtask

    // Stimulus
    initial begin
        // Free run from power-up with reset never asserted
        for (int c = 0; c < 100; c++) do_cycle(1'b0);
        // Three-cycle reset, then run past several toggles
        for (int c = 0; c < 3; c++) do_cycle(1'b1);
        for (int c = 0; c < 26; c++) do_cycle(1'b0);
        // One-cycle reset on edge 27, while LED_1 and LED_3 are high
        do_cycle(1'b1);
        for (int c = 0; c < 60; c++) do_cycle(1'b0);
        // Reset exactly on the edge where LED_2 would hit its terminal count
        do_cycle(1'b1);
        for (int c = 0; c < 9; c++) do_cycle(1'b0);
        do_cycle(1'b1);
        for (int c = 0; c < 30; c++) do_cycle(1'b0);
        // Long run with rare random resets
        for (int c = 0; c < 1000; c++) do_cycle($urandom_range(0, 299) == 0);
        for (int c = 0; c < 2; c++) do_cycle(1'b0);

        for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Monitor: compare levels and measure high/low interval lengths
    initial begin
        int   runlen [4];
        logic prev   [4];
        sb_t  e;
        for (int i = 0; i < 4; i++) begin
            runlen[i] = 0;
            prev[i]   = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_checks++;
                if (u_main_if.led !== e.exp_main) begin
                    n_err++;
                    $display("FAIL leds edge=%0d rst=%0b: got %b, required %b",
                             e.edge_no, e.rst, u_main_if.led, e.exp_main);
                end
                n_checks++;
                if (u_one_if.led !== e.exp_one) begin
                    n_err++;
                    $display("FAIL leds_n1 edge=%0d rst=%0b: got %b, required %b",
                             e.edge_no, e.rst, u_one_if.led, e.exp_one);
                end
                for (int i = 0; i < 4; i++) begin
                    if (e.rst) begin
                        runlen[i] = 0;
                        prev[i]   = 1'b0;
                    end else begin
                        runlen[i]++;
                        if (u_main_if.led[i] !== prev[i]) begin
                            n_checks++;
                            if (runlen[i] != c_N[i]) begin
                                n_err++;
                                $display("FAIL interval led%0d edge=%0d: got %0d cycles, required %0d",
                                         i + 1, e.edge_no, runlen[i], c_N[i]);
                            end
                            runlen[i] = 0;
                            prev[i]   = u_main_if.led[i];
                        end
                    end
                end
            end
        end
    end

endmodule : tb_led_blink
`default_nettype wire
